calc1_port_engine: RTL and testbench

Single-port responder for the calc1 request/response protocol: accepts a two-cycle command (command plus operand 1, then operand 2), executes add, subtract, shift-left or shift-right, and returns a one-cycle response with result data. It is the responder end of the same interface the calc1 benches drive. Each calc1 request port gets one instance, and the instance's response pins feed the out_data/out_resp pins for that port.

---
 rtl/calc1_port_engine.sv | 118 +++++++++++
 tb/tb_calc1_port_engine.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/calc1_port_engine.sv
// calc1 responder: takes a command with operand 1, then operand 2 on the next cycle,
// runs add/sub/shl/shr and returns a single-cycle registered response.
module calc1_port_engine #(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [0:3]  req_cmd_in,
  input  logic [0:31] req_data_in,
  output logic [0:31] out_data,
  output logic [0:1]  out_resp
);

  localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OPND2 = 2'd1,
    ST_EXEC  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  resp_q, resp_d;

  // Packs {resp, data}; overflow, underflow and unknown commands all answer 2 with zero data.
  function automatic logic [33:0] exec_result(input logic [3:0] cmd,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
    logic [32:0] sum;
    logic [33:0] res;
    sum = {1'b0, a} + {1'b0, b};
    res = {2'd2, 32'd0};
    case (cmd)
      4'd1: begin
        if (sum[32]) res = {2'd2, 32'd0};
        else         res = {2'd1, sum[31:0]};
      end
      4'd2: begin
        if (b > a) res = {2'd2, 32'd0};
        else       res = {2'd1, a - b};
      end
      4'd5:    res = {2'd1, a << b[4:0]};
      4'd6:    res = {2'd1, a >> b[4:0]};
      default: res = {2'd2, 32'd0};
    endcase
    return res;
  endfunction

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    cnt_d   = cnt_q;
    resp_d  = 2'd0;
    data_d  = 32'd0;
    case (state_q)
      ST_IDLE: begin
        if (req_cmd_in != 4'd0) begin
          cmd_d   = req_cmd_in;
          op1_d   = req_data_in;
          state_d = ST_OPND2;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OPND2: begin
        // Any command seen here is part of this transaction, not a new request.
        op2_d   = req_data_in;
        cnt_d   = EXEC_LOAD;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          {resp_d, data_d} = exec_result(cmd_q, op1_q, op2_q);
          cnt_d   = 4'd0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_EXEC;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cmd_q   <= 4'd0;
      op1_q   <= 32'd0;
      op2_q   <= 32'd0;
      cnt_q   <= 4'd0;
      resp_q  <= 2'd0;
      data_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      data_q  <= data_d;
    end
  end

  assign out_data = data_q;
  assign out_resp = resp_q;

endmodule

// File: tb/tb_calc1_port_engine.sv
// Randomised scoreboard bench: one stimulus stream feeds engines with 1 and 4 exec cycles,
// a timing-level reference model predicts each response and its edge.
module tb_calc1_port_engine;

  logic        c_clk = 1'b0;
  logic        rst = 1'b1;
  logic [0:3]  cmd_in = 4'd0;
  logic [0:31] data_in = 32'd0;
  logic [0:31] data1, data4;
  logic [0:1]  resp1, resp4;

  always #5 c_clk = ~c_clk;

  calc1_port_engine #(.EXEC_CYCLES(1)) dut1 (
    .c_clk(c_clk), .reset(rst), .req_cmd_in(cmd_in), .req_data_in(data_in),
    .out_data(data1), .out_resp(resp1));

  calc1_port_engine #(.EXEC_CYCLES(4)) dut4 (
    .c_clk(c_clk), .reset(rst), .req_cmd_in(cmd_in), .req_data_in(data_in),
    .out_data(data4), .out_resp(resp4));

  typedef struct {
    int          port;
    int          at;
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc = 0;
  int          total = 0;
  int          passed = 0;
  bit          mon_en = 1'b0;
  int          lat [2] = '{1, 4};
  bit          pend [2] = '{1'b0, 1'b0};
  int          op2_at [2] = '{0, 0};
  int          free_at [2] = '{0, 0};
  logic [3:0]  m_cmd [2];
  logic [31:0] m_op1 [2];
  bit          prev_nz [2] = '{1'b0, 1'b0};

  // Behavioural result: unsigned arithmetic straight from the command rules.
  function automatic void ref_result(input logic [3:0] c, input logic [31:0] a,
                                     input logic [31:0] b, output logic [1:0] r,
                                     output logic [31:0] d);
    longint unsigned s;
    int unsigned     amt;
    r = 2'd2;
    d = 32'd0;
    amt = b % 32;
    s = longint'(a) + longint'(b);
    if (c == 4'd1) begin
      if (s <= 64'hFFFF_FFFF) begin r = 2'd1; d = s[31:0]; end
    end else if (c == 4'd2) begin
      if (a >= b) begin r = 2'd1; d = a - b; end
    end else if (c == 4'd5) begin
      r = 2'd1; d = a << amt;
    end else if (c == 4'd6) begin
      r = 2'd1; d = a >> amt;
    end
  endfunction

  // Reference model: an engine is free again EXEC+2 edges after accepting a command.
  always @(posedge c_clk) begin
    logic [1:0]  r;
    logic [31:0] d;
    cyc = cyc + 1;
    for (int p = 0; p < 2; p++) begin
      if (rst) begin
        for (int i = exp_q.size() - 1; i >= 0; i--)
          if (exp_q[i].port == p && exp_q[i].at >= cyc) exp_q.delete(i);
        pend[p] = 1'b0;
        free_at[p] = cyc + 1;
      end else if (pend[p] && op2_at[p] == cyc) begin
        ref_result(m_cmd[p], m_op1[p], data_in, r, d);
        exp_q.push_back('{port: p, at: cyc + lat[p], resp: r, data: d});
        pend[p] = 1'b0;
      end else if (cyc >= free_at[p] && cmd_in != 4'd0) begin
        m_cmd[p] = cmd_in;
        m_op1[p] = data_in;
        pend[p] = 1'b1;
        op2_at[p] = cyc + 1;
        free_at[p] = cyc + 2 + lat[p];
      end
    end
  end

  // Monitor: pops the oldest expectation for a port whenever that port responds.
  always @(negedge c_clk) begin
    logic [1:0]  r;
    logic [31:0] d;
    int          idx;
    if (mon_en) begin
      for (int p = 0; p < 2; p++) begin
        r = (p == 0) ? resp1 : resp4;
        d = (p == 0) ? data1 : data4;
        idx = -1;
        for (int i = 0; i < exp_q.size(); i++)
          if (idx < 0 && exp_q[i].port == p) idx = i;
        total++;
        if (r != 2'd0) begin
          if (idx < 0) begin
            $display("FAIL unexpected_resp port%0d cyc %0d: got resp=%0d data=%h, required no response",
                     p, cyc, r, d);
          end else if (exp_q[idx].at != cyc || exp_q[idx].resp != r ||
                       exp_q[idx].data != d || prev_nz[p]) begin
            $display("FAIL resp port%0d cyc %0d: got resp=%0d data=%h (prev_nz=%0d), required resp=%0d data=%h at cyc %0d",
                     p, cyc, r, d, prev_nz[p], exp_q[idx].resp, exp_q[idx].data, exp_q[idx].at);
          end else begin
            passed++;
          end
          if (idx >= 0) exp_q.delete(idx);
        end else if (idx >= 0 && exp_q[idx].at <= cyc) begin
          $display("FAIL missing_resp port%0d cyc %0d: got resp=0, required resp=%0d data=%h",
                   p, cyc, exp_q[idx].resp, exp_q[idx].data);
          exp_q.delete(idx);
        end else if (d != 32'd0) begin
          $display("FAIL idle_data port%0d cyc %0d: got data=%h, required 0", p, cyc, d);
        end else begin
          passed++;
        end
        prev_nz[p] = (r != 2'd0);
      end
    end
  end

  task automatic step(input logic [3:0] c, input logic [31:0] d);
    cmd_in = c;
    data_in = d;
    @(posedge c_clk);
    #1;
  endtask

  task automatic req(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] c2);
    step(c, a);
    step(c2, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'd0, $urandom);
  endtask

  task automatic rst_cycle();
    rst = 1'b1;
    step(4'd0, $urandom);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] pick_op();
    case ($urandom_range(0, 4))
      0: return 32'hFFFF_FFFF;
      1: return 32'(($urandom_range(0, 40)));
      2: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] one;
    one = 32'd1;
    rst = 1'b1;
    repeat (4) @(posedge c_clk);
    #1;
    mon_en = 1'b1;
    rst = 1'b0;
    idle(10);

    req(4'd1, 32'h0000_0001, 32'h1FFF_FFFF, 4'd0);
    idle(1);
    req(4'd1, 32'h1FFF_FFFF, 32'h1FFF_FFFF, 4'd0);
    idle(6);
    req(4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 4'd0); idle(4);
    req(4'd2, 32'h0000_0001, 32'h0000_000F, 4'd0); idle(4);
    req(4'd2, 32'h0000_0005, 32'h0000_0005, 4'd0); idle(4);

    for (int k = 0; k < 31; k++) begin
      req(4'd5, one << k, 32'd1, 4'd0);          idle(4);
      req(4'd6, one << k, 32'd1, 4'd0);          idle(4);
      req(4'd5, one << k, 32'hFFFF_FFE3, 4'd0);  idle(4);
    end
    req(4'd6, 32'hDEAD_BEEF, 32'h0000_0020, 4'd0); idle(4);

    req(4'd3,  $urandom, $urandom, 4'd1); idle(4);
    req(4'd4,  $urandom, $urandom, 4'd5); idle(4);
    req(4'd7,  $urandom, $urandom, 4'd2); idle(4);
    req(4'd15, $urandom, $urandom, 4'd6); idle(4);

    req(4'd1, 32'h0000_1000, 32'h0000_0234, 4'd0);
    rst_cycle();
    idle(6);
    req(4'd1, 32'h0000_0010, 32'h0000_0020, 4'd0);
    idle(2);
    rst_cycle();
    idle(6);
    req(4'd2, 32'h0000_0100, 32'h0000_0001, 4'd0);
    idle(4);
    req(4'd1, 32'h0000_0300, 32'h0000_0004, 4'd0);
    idle(6);

    for (int n = 0; n < 120; n++) begin
      req(4'($urandom_range(1, 15)), pick_op(), pick_op(), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 14) == 0) begin
        idle($urandom_range(0, 4));
        rst_cycle();
      end
      idle($urandom_range(0, 6));
    end
    idle(10);

    total++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL leftover_expectations: got %0d pending, required 0", exp_q.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
